// File: rtl/if_pc_gen_pkg.sv
// Shared fetch-stage definitions: FSM states, fault cause encoding and the
// default fetch window / increment used as parameter defaults by if_pc_gen.
package if_pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } if_state_t;

  typedef enum logic [1:0] {
    IF_FAULT_NONE     = 2'd0,
    IF_FAULT_RANGE    = 2'd1,
    IF_FAULT_MISALIGN = 2'd2
  } if_fault_t;

  localparam int unsigned  IF_INC       = 4;
  localparam logic [31:0]  IF_BASE_ADDR = 32'h1000_0000;
  localparam logic [31:0]  IF_MAX_ADDR  = 32'h1000_3FFF;

endpackage

// File: rtl/if_pc_gen_addr_check.sv
// if_addr_check: combinational fetch-window and alignment check.
//   addr  : candidate fetch address
//   ok    : 1 when a fetch of IF_INC bytes at addr is legal
//   cause : IF_FAULT_RANGE / IF_FAULT_MISALIGN / IF_FAULT_NONE
// RANGE wins over MISALIGN when both apply.
module if_addr_check
  import if_pc_gen_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       IF_INC       = if_pc_gen_pkg::IF_INC,
  parameter logic [XLEN-1:0]   IF_BASE_ADDR = if_pc_gen_pkg::IF_BASE_ADDR,
  parameter logic [XLEN-1:0]   IF_MAX_ADDR  = if_pc_gen_pkg::IF_MAX_ADDR
) (
  input  logic [XLEN-1:0] addr,
  output logic            ok,
  output if_fault_t       cause
);

  localparam logic [XLEN:0]   LAST_OFS   = (XLEN+1)'(IF_INC - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IF_INC - 1);

  logic [XLEN:0] last_byte;
  logic          range_bad;
  logic          align_bad;

  always_comb begin
    // Extra carry bit catches an address whose last byte wraps past 2^XLEN.
    last_byte = {1'b0, addr} + LAST_OFS;
    range_bad = (addr < IF_BASE_ADDR) || last_byte[XLEN] ||
                (last_byte[XLEN-1:0] > IF_MAX_ADDR);
    align_bad = (addr & ALIGN_MASK) != '0;
    ok        = !range_bad && !align_bad;
    if (range_bad)      cause = IF_FAULT_RANGE;
    else if (align_bad) cause = IF_FAULT_MISALIGN;
    else                cause = IF_FAULT_NONE;
  end

endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen: instruction-fetch PC generator with valid/ready request port.
//   clk, rst                  : clock, async active-high reset
//   enable                    : fetch enable from core control
//   pc_valid/pc/pc_ready      : fetch request handshake towards imem
//   redirect_valid/_addr      : branch/jump target (ignored in FAULT)
//   trap_valid/_addr          : trap vector (highest priority, exits FAULT)
//   restart                   : leave FAULT back to IDLE at IF_BASE_ADDR
//   fault/fault_cause/_addr   : fault status and offending candidate
//   fetch_count               : saturating count of accepted transfers
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       IF_INC       = if_pc_gen_pkg::IF_INC,
  parameter logic [XLEN-1:0]   IF_BASE_ADDR = if_pc_gen_pkg::IF_BASE_ADDR,
  parameter logic [XLEN-1:0]   IF_MAX_ADDR  = if_pc_gen_pkg::IF_MAX_ADDR,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_addr,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_addr,
  input  logic             restart,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [XLEN-1:0]  fault_addr,
  output logic [CNT_W-1:0] fetch_count
);

  if_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  if_fault_t        cause_q, cause_d;
  logic [XLEN-1:0]  faddr_q, faddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             xfer;
  logic [XLEN:0]    seq_sum;
  logic [XLEN-1:0]  cand;
  logic             cand_vld;
  logic             cand_ok;
  if_fault_t        cand_cause;
  logic             chk_ok;
  if_fault_t        chk_cause;

  if_addr_check #(
    .XLEN         (XLEN),
    .IF_INC       (IF_INC),
    .IF_BASE_ADDR (IF_BASE_ADDR),
    .IF_MAX_ADDR  (IF_MAX_ADDR)
  ) u_addr_check (
    .addr  (cand),
    .ok    (chk_ok),
    .cause (chk_cause)
  );

  assign pc_valid    = (state_q == RUN);
  assign pc          = pc_q;
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;
  assign fault_addr  = faddr_q;
  assign fetch_count = cnt_q;

  // Candidate mux: trap > redirect > sequential. Only the trap leg is
  // honoured in FAULT; redirect is masked there by cand_vld.
  always_comb begin
    xfer    = (state_q == RUN) && pc_ready;
    seq_sum = {1'b0, pc_q} + (XLEN+1)'(IF_INC);
    if (trap_valid)          cand = trap_addr;
    else if (redirect_valid) cand = redirect_addr;
    else                     cand = seq_sum[XLEN-1:0];

    unique case (state_q)
      IDLE:    cand_vld = trap_valid || redirect_valid;
      RUN:     cand_vld = trap_valid || redirect_valid || xfer;
      FAULT:   cand_vld = trap_valid && !restart;
      default: cand_vld = 1'b0;
    endcase

    // A sequential step that carries out of XLEN would wrap; treat as RANGE.
    if (!trap_valid && !redirect_valid && seq_sum[XLEN]) begin
      cand_ok    = 1'b0;
      cand_cause = IF_FAULT_RANGE;
    end else begin
      cand_ok    = chk_ok;
      cand_cause = chk_cause;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    cnt_d   = cnt_q;

    if (xfer && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cand_vld && !cand_ok) begin
          state_d = FAULT;
          cause_d = cand_cause;
          faddr_d = cand;
        end else begin
          if (cand_vld) pc_d = cand;
          if (enable)   state_d = RUN;
        end
      end
      RUN: begin
        if (cand_vld && !cand_ok) begin
          state_d = FAULT;
          cause_d = cand_cause;
          faddr_d = cand;
        end else begin
          if (cand_vld) pc_d = cand;
          // Drop to IDLE only once the current offer is taken.
          if (!enable && xfer) state_d = IDLE;
        end
      end
      FAULT: begin
        if (restart) begin
          state_d = IDLE;
          pc_d    = IF_BASE_ADDR;
          cause_d = IF_FAULT_NONE;
        end else if (cand_vld) begin
          if (cand_ok) begin
            state_d = RUN;
            pc_d    = cand;
            cause_d = IF_FAULT_NONE;
          end else begin
            cause_d = cand_cause;
            faddr_d = cand;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= IF_BASE_ADDR;
      cause_q <= IF_FAULT_NONE;
      faddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen. Accepted fetch PCs are checked by a monitor
// against a queue of hand-computed expected addresses; status outputs are
// checked directly at posedge+1.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pc_ready;
  logic        pc_valid;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        restart;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_pc_gen #(
    .XLEN         (32),
    .IF_INC       (4),
    .IF_BASE_ADDR (32'h1000_0000),
    .IF_MAX_ADDR  (32'h1000_3FFF),
    .CNT_W        (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .pc_ready       (pc_ready),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
    .trap_addr      (trap_addr),
    .restart        (restart),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted request must match the next expected PC.
  always @(negedge clk) begin
    if (!rst && pc_valid && pc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got pc 0x%08h expected no transfer", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc !== e) begin
          errors++;
          $display("FAIL xfer_pc: got 0x%08h expected 0x%08h", pc, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; pc_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;
    trap_valid = 1'b0; trap_addr = '0; restart = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_pc", pc, 32'h1000_0000);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Sequential fetch with a 3-cycle stall at 0x1000_0008.
    exp_q.push_back(32'h1000_0000); exp_q.push_back(32'h1000_0004);
    exp_q.push_back(32'h1000_0008); exp_q.push_back(32'h1000_000C);
    enable = 1'b1; pc_ready = 1'b1;
    cyc();
    chk("run_first_pc", pc, 32'h1000_0000);
    chk("run_first_valid", 32'(pc_valid), 32'd1);
    cyc(); cyc();
    pc_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc, 32'h1000_0008);
      chk("stall_valid", 32'(pc_valid), 32'd1);
      chk("stall_count", fetch_count, 32'd2);
    end
    pc_ready = 1'b1;
    cyc();
    chk("resume_pc", pc, 32'h1000_000C);
    cyc();
    pc_ready = 1'b0;
    chk("seq_count", fetch_count, 32'd4);
    chk("seq_pc", pc, 32'h1000_0010);

    // Trap beats redirect; redirect with a same-cycle transfer still counts.
    redirect_valid = 1'b1; redirect_addr = 32'h1000_0100;
    trap_valid = 1'b1; trap_addr = 32'h1000_0200;
    cyc();
    trap_valid = 1'b0;
    chk("prio_pc", pc, 32'h1000_0200);
    chk("prio_count", fetch_count, 32'd4);
    exp_q.push_back(32'h1000_0200);
    pc_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0; pc_ready = 1'b0;
    chk("redir_pc", pc, 32'h1000_0100);
    chk("redir_count", fetch_count, 32'd5);
    chk("redir_valid", 32'(pc_valid), 32'd1);

    // Step past the top of the window.
    redirect_valid = 1'b1; redirect_addr = 32'h1000_3FFC;
    cyc();
    redirect_valid = 1'b0;
    chk("top_pc", pc, 32'h1000_3FFC);
    exp_q.push_back(32'h1000_3FFC);
    pc_ready = 1'b1;
    cyc();
    pc_ready = 1'b0;
    chk("range_fault", 32'(fault), 32'd1);
    chk("range_cause", 32'(fault_cause), 32'd1);
    chk("range_faddr", fault_addr, 32'h1000_4000);
    chk("range_valid", 32'(pc_valid), 32'd0);
    chk("range_pc", pc, 32'h1000_3FFC);
    chk("range_count", fetch_count, 32'd6);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_fault", 32'(fault), 32'd0);
    chk("restart_pc", pc, 32'h1000_0000);
    chk("restart_valid", 32'(pc_valid), 32'd0);
    cyc();
    chk("restart_run", 32'(pc_valid), 32'd1);

    // Misaligned redirect, ignored redirect, illegal trap, legal trap.
    redirect_valid = 1'b1; redirect_addr = 32'h1000_0102;
    cyc();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd2);
    chk("mis_faddr", fault_addr, 32'h1000_0102);
    chk("mis_pc", pc, 32'h1000_0000);
    redirect_addr = 32'h1000_0300;
    cyc();
    redirect_valid = 1'b0;
    chk("fault_redir_ignored", 32'(fault), 32'd1);
    chk("fault_redir_faddr", fault_addr, 32'h1000_0102);
    trap_valid = 1'b1; trap_addr = 32'h0FFF_FFF2;
    cyc();
    chk("badtrap_fault", 32'(fault), 32'd1);
    chk("badtrap_cause", 32'(fault_cause), 32'd1);
    chk("badtrap_faddr", fault_addr, 32'h0FFF_FFF2);
    trap_addr = 32'h1000_0040;
    cyc();
    trap_valid = 1'b0;
    chk("trap_fault", 32'(fault), 32'd0);
    chk("trap_cause", 32'(fault_cause), 32'd0);
    chk("trap_pc", pc, 32'h1000_0040);
    chk("trap_valid", 32'(pc_valid), 32'd1);
    exp_q.push_back(32'h1000_0040); exp_q.push_back(32'h1000_0044);
    pc_ready = 1'b1;
    cyc(); cyc();
    pc_ready = 1'b0;
    chk("trap_seq_pc", pc, 32'h1000_0048);
    chk("trap_seq_count", fetch_count, 32'd8);

    // enable low: in-flight offer completes before IDLE.
    enable = 1'b0;
    cyc();
    chk("dis_hold_valid", 32'(pc_valid), 32'd1);
    exp_q.push_back(32'h1000_0048);
    pc_ready = 1'b1;
    cyc();
    pc_ready = 1'b0;
    chk("dis_idle_valid", 32'(pc_valid), 32'd0);
    chk("dis_idle_pc", pc, 32'h1000_004C);
    redirect_valid = 1'b1; redirect_addr = 32'h1000_0020;
    cyc();
    redirect_valid = 1'b0;
    chk("idle_redir_pc", pc, 32'h1000_0020);
    chk("idle_redir_valid", 32'(pc_valid), 32'd0);

    // Async reset mid-stall.
    enable = 1'b1;
    cyc(); cyc();
    chk("stall2_pc", pc, 32'h1000_0020);
    chk("stall2_valid", 32'(pc_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(pc_valid), 32'd0);
    chk("arst_pc", pc, 32'h1000_0000);
    chk("arst_count", fetch_count, 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_valid", 32'(pc_valid), 32'd1);
    chk("post_rst_pc", pc, 32'h1000_0000);
    exp_q.push_back(32'h1000_0000);
    pc_ready = 1'b1;
    cyc();
    pc_ready = 1'b0;
    chk("post_rst_count", fetch_count, 32'd1);

    cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
